// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the divide iteration count.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/div_radix2.sv
// Unsigned restoring radix-2 divider: one quotient bit per enabled step.
// quotient/remainder show the value the registers will hold after this step.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dsr_reg;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_next;

  // rem_reg < divisor always holds (or divisor is zero and rem never exceeds
  // WIDTH-1 shifted bits), so bit WIDTH of diff is a clean borrow flag.
  always_comb begin
    partial  = {rem_reg, quo_reg[WIDTH-1]};
    diff     = partial - {1'b0, dsr_reg};
    fits     = ~diff[WIDTH];
    quo_next = {quo_reg[WIDTH-2:0], fits};
    rem_next = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end

  assign quotient  = step ? quo_next : quo_reg;
  assign remainder = step ? rem_next : rem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_reg <= '0;
      rem_reg <= '0;
      dsr_reg <= '0;
    end else if (load) begin
      quo_reg <= dividend;
      rem_reg <= '0;
      dsr_reg <= divisor;
    end else if (step) begin
      quo_reg <= quo_next;
      rem_reg <= rem_next;
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the Execute stage; busy freezes the
// pipeline until the registered HI/LO result is presented in DONE.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             stall_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             mul_signed_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             valid_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic               accept;
  logic               div_signed;
  logic               b_zero;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;
  logic               div_load;
  logic               div_step;
  logic [WIDTH-1:0]   core_q;
  logic [WIDTH-1:0]   core_r;
  logic [WIDTH-1:0]   q_final;
  logic [WIDTH-1:0]   r_final;

  assign accept     = (state_reg == ST_IDLE) & start_i & ~flush_i;
  assign div_signed = (op_i == OP_DIV);
  assign b_zero     = (b_i == '0);
  assign a_mag      = (div_signed & a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
  assign b_mag      = (div_signed & b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

  // Sign-extend only for MULT; the low 2*WIDTH bits of the wide product are
  // then correct for both signed and unsigned operands.
  assign a_ext   = {{WIDTH{mul_signed_reg & a_reg[WIDTH-1]}}, a_reg};
  assign b_ext   = {{WIDTH{mul_signed_reg & b_reg[WIDTH-1]}}, b_reg};
  assign product = a_ext * b_ext;

  assign div_load = accept & op_i[1];
  assign div_step = (state_reg == ST_DIV) & ~flush_i;

  div_radix2 #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quotient (core_q),
    .remainder(core_r)
  );

  assign q_final = neg_q_reg ? (~core_q + 1'b1) : core_q;
  assign r_final = neg_r_reg ? (~core_r + 1'b1) : core_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      mul_signed_reg <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
      valid_reg      <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
    end else if (flush_i) begin
      state_reg <= ST_IDLE;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            mul_signed_reg <= (op_i == OP_MULT);
            a_reg          <= a_i;
            b_reg          <= b_i;
            // A zero divisor leaves the raw unsigned core result untouched.
            neg_q_reg      <= div_signed & ~b_zero & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r_reg      <= div_signed & ~b_zero & a_i[WIDTH-1];
            cnt_reg        <= '0;
            state_reg      <= op_i[1] ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL: begin
          hi_reg    <= product[2*WIDTH-1:WIDTH];
          lo_reg    <= product[WIDTH-1:0];
          valid_reg <= 1'b1;
          state_reg <= ST_DONE;
        end
        ST_DIV: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            hi_reg    <= r_final;
            lo_reg    <= q_final;
            valid_reg <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          // start_i is still asserted by the same instruction here; ignore it.
          if (!stall_i) begin
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = (state_reg == ST_MUL) | (state_reg == ST_DIV) | accept;
  assign valid_o = valid_reg;
  assign hi_o    = hi_reg;
  assign lo_o    = lo_reg;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: expected HI/LO pushed to a scoreboard when
// an op is issued and popped when the unit presents a result.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  muldiv_iter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .flush_i(flush),
    .stall_i(stall),
    .busy_o (busy),
    .valid_o(valid),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at the current (post-edge) time, follow it through DONE,
  // optionally stall there, then release and confirm return to IDLE.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input int exp_busy, input int stall_n);
    int cnt;
    logic [63:0] want;
    logic [63:0] held;
    cnt = 0;
    sb.push_back({eh, el});
    op = o; a = x; b = y; start = 1'b1;
    #1;
    check({tag, " busy_first"}, 64'(busy), 64'd1);
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
    check({tag, " busy_len"}, 64'(cnt), 64'(exp_busy));
    check({tag, " valid"}, 64'(valid), 64'd1);
    if (sb.size() == 0) begin
      check({tag, " sb_nonempty"}, 64'd0, 64'd1);
      want = '0;
    end else begin
      want = sb.pop_front();
      check({tag, " hilo"}, {hi, lo}, want);
    end
    held = {hi, lo};
    if (stall_n > 0) begin
      stall = 1'b1;
      for (int i = 0; i < stall_n; i++) begin
        tick();
        check({tag, " stall_valid"}, 64'(valid), 64'd1);
        check({tag, " stall_busy"}, 64'(busy), 64'd0);
        check({tag, " stall_hilo"}, {hi, lo}, held);
      end
    end
    stall = 1'b0;
    start = 1'b0;
    tick();
    check({tag, " idle_valid"}, 64'(valid), 64'd0);
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
    check({tag, " idle_hilo"}, {hi, lo}, held);
    $display("op %s a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", tag, x, y, held[63:32], held[31:0], cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] prior;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst valid", 64'(valid), 64'd0);
    check("rst hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst valid", 64'(valid), 64'd0);
    check("post_rst hilo", {hi, lo}, 64'd0);

    // start together with flush in IDLE must not engage the unit
    start = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3; flush = 1'b1;
    #1;
    check("flush_idle busy", 64'(busy), 64'd0);
    tick();
    check("flush_idle busy2", 64'(busy), 64'd0);
    check("flush_idle valid", 64'(valid), 64'd0);
    start = 1'b0; flush = 1'b0;
    tick();

    run_op("MULT -2*3",  OP_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 2, 0);
    run_op("MULTU -2*3", OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 2, 0);
    run_op("DIV -7/2",   OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0);
    run_op("DIV 7/-2",   OP_DIV,   32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 0);
    run_op("DIVU 0x1234/0", OP_DIVU, 32'h1234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 33, 0);
    run_op("DIV ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 0);
    run_op("DIVU max/16", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 33, 0);
    run_op("DIVU 100/7", OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 33, 0);

    // flush at divide iteration 10
    prior = {hi, lo};
    op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    repeat (10) tick();
    flush = 1'b1;
    #1;
    check("flush_div busy_before", 64'(busy), 64'd1);
    tick();
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_div busy_after", 64'(busy), 64'd0);
    check("flush_div valid", 64'(valid), 64'd0);
    check("flush_div hilo", {hi, lo}, prior);
    $display("op flush DIV at iteration 10 hi=%h lo=%h", hi, lo);
    tick();

    run_op("MULT after flush", OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 2, 0);
    run_op("MULTU stall5", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2, 5);

    // reset at divide iteration 20
    op = OP_DIV; a = 32'h12345678; b = 32'h10; start = 1'b1;
    repeat (20) tick();
    check("rst_div busy_before", 64'(busy), 64'd1);
    rst = 1'b1; start = 1'b0;
    #1;
    check("rst_div busy", 64'(busy), 64'd0);
    check("rst_div valid", 64'(valid), 64'd0);
    check("rst_div hilo", {hi, lo}, 64'd0);
    $display("op reset during DIV iteration 20 hi=%h lo=%h", hi, lo);
    tick();
    rst = 1'b0;
    tick();
    check("rst_div idle_busy", 64'(busy), 64'd0);

    run_op("MULTU 6*7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 2, 0);
    check("sb drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
